score_scan: RTL
===============

Name: score_scan

Overview:
- Upstream feeder for the 7-segment nibble decoder in the 2-player catch display path.
- Keeps one BCD score (00–99) per player from catch-event inputs and detects the winning score.
- Time-multiplexes the four score digits onto a single 4-bit nibble bus (w,x,y,z) plus active-low digit anode selects.
- The decoder's 7-bit segment output drives the common segment lines.

Parameters:
- SCAN_DIV, 16, width of the free-running refresh counter; the digit advances once every 2^SCAN_DIV clocks (use 2 in simulation).
- WIN_SCORE, 10, decimal score at which a player wins; legal range 1..99.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- clr  in  1  synchronous clear of scores and game state
- p1_point  in  1  player 1 catch event, level; a rising edge counts one point
- p2_point  in  1  player 2 catch event, level; a rising edge counts one point
- w  out  1  nibble bit 3 (MSB) to the decoder
- x  out  1  nibble bit 2
- y  out  1  nibble bit 1
- z  out  1  nibble bit 0 (LSB)
- an  out  4  digit anode enables, active-low
- game_over  out  1  high once a player has reached WIN_SCORE
- winner  out  2  01 = player 1, 10 = player 2, 11 = tie, 00 = none

Behaviour:
- Clock and reset (decided): one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset (asserted at any time, takes effect immediately):
  - Scores go to 00, game_over=0, winner=00.
  - Refresh counter and digit index go to 0; edge registers go to 0.
  - Outputs go to an=4'b1111 and {w,x,y,z}=4'b0000.
- Edge detect: one register per player samples pN_point every clock. A point event is pN_point=1 while the previous sample is 0. A level held high counts once.
- Score update:
  - A point event increments that player's BCD score on the same clock edge.
  - The ones digit counts 0..9. At 9 it wraps to 0 and the tens digit increments.
  - The score saturates at 99; a point at 99 leaves it at 99.
  - Ones and tens are always 0..9; no hex values are ever emitted.
- Win detection:
  - When an increment makes a score equal WIN_SCORE, game_over and the matching winner bit are set at the same clock edge.
  - If both players reach WIN_SCORE on the same edge, winner=11.
  - While game_over=1, point events are ignored and scores freeze.
- Simultaneous points: both scores increment on that edge.
- clr:
  - Sets scores to 00, game_over=0, winner=00.
  - Takes priority over point events in the same cycle.
  - Edge registers keep sampling during clr, so a level held through clr release does not count.
  - The refresh counter and digit index are not affected.
- Scan:
  - The refresh counter increments every clock.
  - When the counter is all-ones it wraps, and on that same edge the digit index increments modulo 4.
  - Digit index to source and anode:
    - 0: P1 ones, an=1110
    - 1: P1 tens, an=1101
    - 2: P2 ones, an=1011
    - 3: P2 tens, an=0111
- Blanking: a tens digit of 0 is blanked: its anode is driven 1111 and the nibble is still output.
- Output timing:
  - {w,x,y,z} and an are registered together, so they always change on the same edge.
  - Latency is one clock after a change in digit index or score. A score change appears on the bus only while its digit is selected.
- Nibble order: w is the MSB.

Test Plan:
- Reset then release, SCAN_DIV=2 -> first clock an=1110, wxyz=0000; digit index steps every 4 clocks; P1 tens and P2 tens are blanked (an=1111 in those slots).
- p1_point held high 20 clocks -> P1 score 01 only. Three separate pulses -> digit 0 shows wxyz=0011.
- 9 pulses on P1, then one more -> score 10. Digit 0 shows 0000; digit 1 shows 0001 with an=1101.
- WIN_SCORE=10, P1 reaches 10 -> game_over=1, winner=01 on the same edge. Further P1 or P2 pulses leave scores unchanged.
- Both at 9, same-cycle rising edges -> both scores 10, winner=11.
- clr together with a p2 edge -> scores 00, P2 not incremented, game_over=0. Assert rst_n low mid-scan -> an=1111 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/score_scan_if.sv
// score_scan_if: catch-event inputs and scanned display outputs.
// master drives clr/p1_point/p2_point; slave drives w,x,y,z,an,game_over,winner.
interface score_scan_if;
  logic       clr;
  logic       p1_point;
  logic       p2_point;
  logic       w;
  logic       x;
  logic       y;
  logic       z;
  logic [3:0] an;
  logic       game_over;
  logic [1:0] winner;

  modport master (
    output clr, p1_point, p2_point,
    input  w, x, y, z, an, game_over, winner
  );

  modport slave (
    input  clr, p1_point, p2_point,
    output w, x, y, z, an, game_over, winner
  );
endinterface

// File: rtl/score_scan.sv
// score_scan: two BCD scores from catch events, win detect, 4-digit scan.
// Ports: clk, rst_n (async, active-low), bus (score_scan_if.slave).
module score_scan #(
  parameter int SCAN_DIV  = 16,
  parameter int WIN_SCORE = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  score_scan_if.slave  bus
);

  localparam logic [7:0] WIN_BCD =
    {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};

  logic                p1_q;
  logic                p2_q;
  logic                ev1;
  logic                ev2;
  logic [7:0]          s1;
  logic [7:0]          s2;
  logic [7:0]          n1;
  logic [7:0]          n2;
  logic                hit1;
  logic                hit2;
  logic                go;
  logic [1:0]          win;
  logic [SCAN_DIV-1:0] cnt;
  logic [1:0]          idx;
  logic [3:0]          nib_d;
  logic [3:0]          an_d;
  logic [3:0]          nib_q;
  logic [3:0]          an_q;

  // BCD increment, saturating at 99
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (v != 8'h99) begin
      if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
      else                r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  assign ev1 = bus.p1_point & ~p1_q;
  assign ev2 = bus.p2_point & ~p2_q;

  always_comb begin
    n1   = s1;
    n2   = s2;
    hit1 = 1'b0;
    hit2 = 1'b0;
    if (!go) begin
      if (ev1) n1 = bcd_inc(s1);
      if (ev2) n2 = bcd_inc(s2);
      hit1 = ev1 && (n1 == WIN_BCD);
      hit2 = ev2 && (n2 == WIN_BCD);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_q <= 1'b0;
      p2_q <= 1'b0;
    end else begin
      // keep sampling through clr so a held level never counts
      p1_q <= bus.p1_point;
      p2_q <= bus.p2_point;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1  <= 8'h00;
      s2  <= 8'h00;
      go  <= 1'b0;
      win <= 2'b00;
    end else if (bus.clr) begin
      s1  <= 8'h00;
      s2  <= 8'h00;
      go  <= 1'b0;
      win <= 2'b00;
    end else begin
      s1 <= n1;
      s2 <= n2;
      if (hit1 || hit2) begin
        go  <= 1'b1;
        win <= {hit2, hit1};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= 2'd0;
    end else begin
      cnt <= cnt + SCAN_DIV'(1);
      if (&cnt) idx <= idx + 2'd1;
    end
  end

  always_comb begin
    nib_d = 4'd0;
    an_d  = 4'b1111;
    unique case (1'b1)
      idx == 2'd0: begin
        nib_d = s1[3:0];
        an_d  = 4'b1110;
      end
      idx == 2'd1: begin
        nib_d = s1[7:4];
        an_d  = (s1[7:4] == 4'd0) ? 4'b1111 : 4'b1101;
      end
      idx == 2'd2: begin
        nib_d = s2[3:0];
        an_d  = 4'b1011;
      end
      idx == 2'd3: begin
        nib_d = s2[7:4];
        an_d  = (s2[7:4] == 4'd0) ? 4'b1111 : 4'b0111;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nib_q <= 4'd0;
      an_q  <= 4'b1111;
    end else begin
      nib_q <= nib_d;
      an_q  <= an_d;
    end
  end

  assign bus.w         = nib_q[3];
  assign bus.x         = nib_q[2];
  assign bus.y         = nib_q[1];
  assign bus.z         = nib_q[0];
  assign bus.an        = an_q;
  assign bus.game_over = go;
  assign bus.winner    = win;

endmodule
